// File: rtl/vga_overlay_pkg.sv
// Shared definitions for the VGA sprite overlay: register map, field positions,
// colour width and the sprite configuration record copied at each frame start.
package vga_overlay_pkg;

    localparam int COLOR_W = 6;
    localparam int POS_W   = 10;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_POS      = 6'h04;
    localparam logic [5:0] ADDR_FRAME    = 6'h08;
    localparam logic [5:0] ADDR_BMP_BASE = 6'h10;
    localparam logic [5:0] ADDR_BMP_LAST = 6'h2C;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_FG_LSB = 8;
    localparam int CTRL_BG_LSB = 16;
    localparam int POS_X_LSB   = 0;
    localparam int POS_Y_LSB   = 16;

    typedef struct packed {
        logic               en;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic [POS_W-1:0]   x;
        logic [POS_W-1:0]   y;
    } sprite_cfg_t;

    function automatic logic is_bmp_addr(input logic [5:0] addr);
        return (addr >= ADDR_BMP_BASE) && (addr <= ADDR_BMP_LAST) && (addr[1:0] == 2'b00);
    endfunction

    // Each bitmap word holds two consecutive rows; returns the word index 0..7.
    function automatic logic [2:0] bmp_word(input logic [5:0] addr);
        return 3'((addr - ADDR_BMP_BASE) >> 2);
    endfunction

endpackage

// File: rtl/vga_sprite_regs.sv
// Sprite register file: pending/active CTRL+POS with frame-start shadow copy,
// direct-write bitmap, frame counter, sticky frame interrupt and read mux.
module vga_sprite_regs
    import vga_overlay_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_vsync,
    input  logic [5:0]         i_cfg_addr,
    input  logic [31:0]        i_cfg_wdata,
    input  logic               i_cfg_we,
    input  logic               i_irq_clear,
    input  logic [3:0]         i_row_sel,
    output logic               o_act_en,
    output logic [COLOR_W-1:0] o_act_fg,
    output logic [COLOR_W-1:0] o_act_bg,
    output logic [POS_W-1:0]   o_act_x,
    output logic [POS_W-1:0]   o_act_y,
    output logic [15:0]        o_row_bits,
    output logic [31:0]        o_cfg_rdata,
    output logic               o_frame_irq
);

    sprite_cfg_t      r_pend;
    sprite_cfg_t      r_act;
    logic [15:0]      r_bmp [16];
    logic             r_vsync_q;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_frame_irq;

    logic             w_vs_edge;
    logic             w_bmp_hit;
    logic [2:0]       w_bmp_word;
    logic [31:0]      w_rdata;

    assign w_vs_edge  = i_vsync & ~r_vsync_q;
    assign w_bmp_hit  = is_bmp_addr(i_cfg_addr);
    assign w_bmp_word = bmp_word(i_cfg_addr);

    // vsync history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q <= 1'b0;
        end else begin
            r_vsync_q <= i_vsync;
        end
    end

    // CPU-visible pending CTRL/POS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (i_cfg_we) begin
            case (i_cfg_addr)
                ADDR_CTRL: begin
                    r_pend.en <= i_cfg_wdata[CTRL_EN_BIT];
                    r_pend.fg <= i_cfg_wdata[CTRL_FG_LSB +: COLOR_W];
                    r_pend.bg <= i_cfg_wdata[CTRL_BG_LSB +: COLOR_W];
                end
                ADDR_POS: begin
                    r_pend.x <= i_cfg_wdata[POS_X_LSB +: POS_W];
                    r_pend.y <= i_cfg_wdata[POS_Y_LSB +: POS_W];
                end
                default: r_pend <= r_pend;
            endcase
        end else begin
            r_pend <= r_pend;
        end
    end

    // Active set samples the pre-write pending value, so a same-cycle write lands a frame later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= '0;
        end else if (w_vs_edge) begin
            r_act <= r_pend;
        end else begin
            r_act <= r_act;
        end
    end

    // Bitmap rows, written directly with no shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_bmp[i] <= 16'h0000;
            end
        end else if (i_cfg_we && w_bmp_hit) begin
            r_bmp[{w_bmp_word, 1'b0}] <= i_cfg_wdata[15:0];
            r_bmp[{w_bmp_word, 1'b1}] <= i_cfg_wdata[31:16];
        end else begin
            r_bmp <= r_bmp;
        end
    end

    // Frame counter and sticky interrupt; a frame start beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_frame_irq <= 1'b0;
        end else if (w_vs_edge) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_frame_irq <= 1'b1;
        end else if (i_irq_clear) begin
            r_frame_cnt <= r_frame_cnt;
            r_frame_irq <= 1'b0;
        end else begin
            r_frame_cnt <= r_frame_cnt;
            r_frame_irq <= r_frame_irq;
        end
    end

    // Combinational read mux
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (i_cfg_addr)
            ADDR_CTRL: begin
                w_rdata[CTRL_EN_BIT]              = r_pend.en;
                w_rdata[CTRL_FG_LSB +: COLOR_W]   = r_pend.fg;
                w_rdata[CTRL_BG_LSB +: COLOR_W]   = r_pend.bg;
            end
            ADDR_POS: begin
                w_rdata[POS_X_LSB +: POS_W]       = r_pend.x;
                w_rdata[POS_Y_LSB +: POS_W]       = r_pend.y;
            end
            ADDR_FRAME: w_rdata = 32'(r_frame_cnt);
            default: begin
                if (w_bmp_hit) begin
                    w_rdata = {r_bmp[{w_bmp_word, 1'b1}], r_bmp[{w_bmp_word, 1'b0}]};
                end else begin
                    w_rdata = 32'h0000_0000;
                end
            end
        endcase
    end

    assign o_act_en    = r_act.en;
    assign o_act_fg    = r_act.fg;
    assign o_act_bg    = r_act.bg;
    assign o_act_x     = r_act.x;
    assign o_act_y     = r_act.y;
    assign o_row_bits  = r_bmp[i_row_sel];
    assign o_cfg_rdata = w_rdata;
    assign o_frame_irq = r_frame_irq;

endmodule

// File: rtl/vga_sprite_overlay.sv
// Pixel stage behind the VGA timing generator: 16x16 1-bit sprite over a flat
// background, two-cycle pipeline with delay-matched syncs.
module vga_sprite_overlay
    import vga_overlay_pkg::*;
#(
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic               display_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [5:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    input  logic               cfg_we,
    output logic [31:0]        cfg_rdata,
    input  logic               irq_clear,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               frame_irq
);

    logic               w_act_en;
    logic [COLOR_W-1:0] w_act_fg;
    logic [COLOR_W-1:0] w_act_bg;
    logic [POS_W-1:0]   w_act_x;
    logic [POS_W-1:0]   w_act_y;
    logic [15:0]        w_row_bits;
    logic [10:0]        w_dx;
    logic [10:0]        w_dy;
    logic               w_inside;
    logic               w_pix_on;

    logic               r_disp_s1;
    logic               r_hs_s1;
    logic               r_vs_s1;
    logic               r_inside_s1;
    logic [15:0]        r_row_s1;
    logic [3:0]         r_col_s1;
    logic [COLOR_W-1:0] r_fg_s1;
    logic [COLOR_W-1:0] r_bg_s1;

    logic [COLOR_W-1:0] r_rgb;
    logic               r_hs_s2;
    logic               r_vs_s2;

    // 11-bit unsigned offsets: left/above the sprite wraps to >= 1025, so no horizontal wrap-around
    assign w_dx     = {1'b0, hpos} - {1'b0, w_act_x};
    assign w_dy     = {1'b0, vpos} - {1'b0, w_act_y};
    assign w_inside = w_act_en & (w_dx < 11'(SPR_W)) & (w_dy < 11'(SPR_H));

    vga_sprite_regs #(
        .CNT_W (CNT_W)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vsync     (vsync_in),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_wdata (cfg_wdata),
        .i_cfg_we    (cfg_we),
        .i_irq_clear (irq_clear),
        .i_row_sel   (w_dy[3:0]),
        .o_act_en    (w_act_en),
        .o_act_fg    (w_act_fg),
        .o_act_bg    (w_act_bg),
        .o_act_x     (w_act_x),
        .o_act_y     (w_act_y),
        .o_row_bits  (w_row_bits),
        .o_cfg_rdata (cfg_rdata),
        .o_frame_irq (frame_irq)
    );

    // Stage 1: hit test, row fetch and timing capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_s1   <= 1'b0;
            r_hs_s1     <= 1'b0;
            r_vs_s1     <= 1'b0;
            r_inside_s1 <= 1'b0;
            r_row_s1    <= 16'h0000;
            r_col_s1    <= 4'h0;
            r_fg_s1     <= '0;
            r_bg_s1     <= '0;
        end else begin
            r_disp_s1   <= display_on;
            r_hs_s1     <= hsync_in;
            r_vs_s1     <= vsync_in;
            r_inside_s1 <= w_inside;
            r_row_s1    <= w_row_bits;
            r_col_s1    <= w_dx[3:0];
            r_fg_s1     <= w_act_fg;
            r_bg_s1     <= w_act_bg;
        end
    end

    // Column 0 is the leftmost pixel and lives in bit 15
    assign w_pix_on = r_inside_s1 & r_row_s1[4'd15 - r_col_s1];

    // Stage 2: colour select and sync alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb   <= '0;
            r_hs_s2 <= 1'b0;
            r_vs_s2 <= 1'b0;
        end else begin
            r_hs_s2 <= r_hs_s1;
            r_vs_s2 <= r_vs_s1;
            if (!r_disp_s1) begin
                r_rgb <= '0;
            end else if (w_pix_on) begin
                r_rgb <= r_fg_s1;
            end else begin
                r_rgb <= r_bg_s1;
            end
        end
    end

    assign rgb_out   = r_rgb;
    assign hsync_out = r_hs_s2;
    assign vsync_out = r_vs_s2;

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Randomised and directed bench for vga_sprite_overlay against a pixel-rule
// reference model (sprite rectangle test, pending/active shadow, frame events).
module tb_vga_sprite_overlay;

    localparam int CNT_W = 8;
    localparam logic [5:0] A_CTRL  = 6'h00;
    localparam logic [5:0] A_POS   = 6'h04;
    localparam logic [5:0] A_FRAME = 6'h08;
    localparam logic [5:0] A_BMP0  = 6'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hpos, vpos;
    logic        display_on, hsync_in, vsync_in;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        cfg_we, irq_clear;
    logic [5:0]  rgb_out;
    logic        hsync_out, vsync_out, frame_irq;

    always #5 clk = ~clk;

    vga_sprite_overlay #(.SPR_W(16), .SPR_H(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_we(cfg_we), .cfg_rdata(cfg_rdata), .irq_clear(irq_clear), .rgb_out(rgb_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_irq(frame_irq)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int          p_en, p_fg, p_bg, p_x, p_y;
    int          a_en, a_fg, a_bg, a_x, a_y;
    logic [15:0] m_bmp [16];
    int          m_cnt;
    bit          m_irq, m_vsq;
    logic [5:0]  q_rgb, exp_rgb;
    logic        q_hs, q_vs, exp_hs, exp_vs;

    function automatic void model_reset();
        p_en = 0; p_fg = 0; p_bg = 0; p_x = 0; p_y = 0;
        a_en = 0; a_fg = 0; a_bg = 0; a_x = 0; a_y = 0;
        for (int i = 0; i < 16; i++) m_bmp[i] = 16'h0000;
        m_cnt = 0; m_irq = 1'b0; m_vsq = 1'b0;
        q_rgb = 6'h00; q_hs = 1'b0; q_vs = 1'b0;
        exp_rgb = 6'h00; exp_hs = 1'b0; exp_vs = 1'b0;
    endfunction

    function automatic logic [5:0] model_pixel();
        int dx, dy;
        dx = int'(hpos) - a_x;
        dy = int'(vpos) - a_y;
        if (!display_on) return 6'h00;
        if (a_en != 0 && dx >= 0 && dx < 16 && dy >= 0 && dy < 16 && m_bmp[dy][15 - dx])
            return 6'(a_fg);
        return 6'(a_bg);
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] addr);
        int a;
        int k;
        a = int'(addr);
        if (a == 0) return 32'(p_bg * 65536 + p_fg * 256 + p_en);
        if (a == 4) return 32'(p_y * 65536 + p_x);
        if (a == 8) return 32'(m_cnt);
        if (a >= 16 && a <= 44 && a % 4 == 0) begin
            k = (a - 16) / 2;
            return {m_bmp[k + 1], m_bmp[k]};
        end
        return 32'h0000_0000;
    endfunction

    function automatic void model_edge();
        int a, k;
        if (vsync_in && !m_vsq) begin
            a_en = p_en; a_fg = p_fg; a_bg = p_bg; a_x = p_x; a_y = p_y;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_irq = 1'b1;
        end else if (irq_clear) begin
            m_irq = 1'b0;
        end
        m_vsq = vsync_in;
        if (cfg_we) begin
            a = int'(cfg_addr);
            if (a == 0) begin
                p_en = int'(cfg_wdata[0]); p_fg = int'(cfg_wdata[13:8]); p_bg = int'(cfg_wdata[21:16]);
            end else if (a == 4) begin
                p_x = int'(cfg_wdata[9:0]); p_y = int'(cfg_wdata[25:16]);
            end else if (a >= 16 && a <= 44 && a % 4 == 0) begin
                k = (a - 16) / 4;
                m_bmp[2 * k] = cfg_wdata[15:0];
                m_bmp[2 * k + 1] = cfg_wdata[31:16];
            end
        end
    endfunction

    // One clock: model consumes current inputs, DUT clocks, expectations shift by one stage.
    task automatic tick();
        logic [5:0] e_rgb;
        logic e_hs, e_vs;
        e_rgb = model_pixel();
        e_hs = hsync_in;
        e_vs = vsync_in;
        model_edge();
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        irq_clear = 1'b0;
        @(negedge clk);
        exp_rgb = q_rgb; exp_hs = q_hs; exp_vs = q_vs;
        q_rgb = e_rgb; q_hs = e_hs; q_vs = e_vs;
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
        cfg_addr = addr; cfg_wdata = data; cfg_we = 1'b1;
        tick();
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1; tick();
        vsync_in = 1'b0; tick();
    endtask

    function automatic logic [31:0] pos_word(input int x, input int y);
        return {6'h00, 10'(y), 6'h00, 10'(x)};
    endfunction

    task automatic test_reset();
        cfg_write(A_CTRL, 32'h0015_0000);
        vsync_pulse();
        hsync_in = 1'b1; display_on = 1'b1; hpos = 10'd200; vpos = 10'd100;
        tick(); tick();
        checks++;
        if (rgb_out !== 6'h15 || hsync_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_prime: rgb=%h hs=%b want rgb=15 hs=1", rgb_out, hsync_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rgb_out !== 6'h00 || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rgb=%h hs=%b vs=%b want 0", rgb_out, hsync_out, vsync_out);
        end
        checks++;
        if (frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", frame_irq);
        end
        model_reset();
        hsync_in = 1'b0; display_on = 1'b0; vsync_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_addr = A_FRAME;
        #1;
        checks++;
        if (cfg_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %h want 0", cfg_rdata);
        end
        cfg_addr = A_CTRL;
        #1;
        checks++;
        if (cfg_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want 0", cfg_rdata);
        end
    endtask

    task automatic test_shadow();
        int hs [4] = '{100, 115, 101, 116};
        logic [5:0] post [5] = '{6'h00, 6'h0C, 6'h0C, 6'h03, 6'h03};
        cfg_write(A_BMP0, 32'h0000_8001);
        cfg_write(A_CTRL, 32'h0003_0C01);
        cfg_write(A_POS, pos_word(100, 50));
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin hpos = 10'(hs[i]); vpos = 10'd50; display_on = 1'b1; end
            else display_on = 1'b0;
            tick();
            checks++;
            if (rgb_out !== 6'h00) begin
                errors++;
                $display("FAIL shadow_pre[%0d]: got %h want 00", i, rgb_out);
            end
        end
        vsync_pulse();
        checks++;
        if (frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL shadow_irq: got %b want 1", frame_irq);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin hpos = 10'(hs[i]); vpos = 10'd50; display_on = 1'b1; end
            else display_on = 1'b0;
            tick();
            checks++;
            if (rgb_out !== post[i] || rgb_out !== exp_rgb) begin
                errors++;
                $display("FAIL shadow_post[%0d]: got %h want %h (model %h)", i, rgb_out, post[i], exp_rgb);
            end
        end
    endtask

    task automatic test_sync_latency();
        logic [2:0] stim [4] = '{3'b101, 3'b011, 3'b000, 3'b000};
        logic       w_hs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       w_vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0] w_rgb [4] = '{6'h00, 6'h03, 6'h03, 6'h00};
        display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; hpos = 10'd0; vpos = 10'd0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            hsync_in = stim[i][2]; vsync_in = stim[i][1]; display_on = stim[i][0];
            tick();
            checks++;
            if (hsync_out !== w_hs[i] || vsync_out !== w_vs[i] || rgb_out !== w_rgb[i]) begin
                errors++;
                $display("FAIL sync_latency[%0d]: hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                         i, hsync_out, vsync_out, rgb_out, w_hs[i], w_vs[i], w_rgb[i]);
            end
        end
    endtask

    task automatic test_clip();
        int n_fg;
        for (int k = 0; k < 8; k++) cfg_write(6'(16 + 4 * k), 32'hFFFF_FFFF);
        cfg_write(A_POS, pos_word(630, 470));
        vsync_pulse();
        n_fg = 0;
        for (int i = 0; i <= 26; i++) begin
            if (i < 26) begin hpos = 10'(620 + i); vpos = 10'd475; display_on = (620 + i) < 640; end
            else display_on = 1'b0;
            tick();
            checks++;
            if (rgb_out !== exp_rgb) begin
                errors++;
                $display("FAIL clip_h[%0d]: got %h want %h", i, rgb_out, exp_rgb);
            end
            if (rgb_out == 6'h0C) n_fg++;
        end
        checks++;
        if (n_fg != 10) begin
            errors++;
            $display("FAIL clip_h_count: got %0d want 10", n_fg);
        end
        n_fg = 0;
        for (int i = 0; i <= 21; i++) begin
            if (i < 21) begin hpos = 10'd635; vpos = 10'(465 + i); display_on = (465 + i) < 480; end
            else display_on = 1'b0;
            tick();
            checks++;
            if (rgb_out !== exp_rgb) begin
                errors++;
                $display("FAIL clip_v[%0d]: got %h want %h", i, rgb_out, exp_rgb);
            end
            if (rgb_out == 6'h0C) n_fg++;
        end
        checks++;
        if (n_fg != 10) begin
            errors++;
            $display("FAIL clip_v_count: got %0d want 10", n_fg);
        end
        cfg_write(A_POS, pos_word(1020, 0));
        vsync_pulse();
        n_fg = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin hpos = 10'((1016 + i) % 1024); vpos = 10'd5; display_on = 1'b1; end
            else display_on = 1'b0;
            tick();
            checks++;
            if (rgb_out !== exp_rgb) begin
                errors++;
                $display("FAIL nowrap[%0d]: got %h want %h", i, rgb_out, exp_rgb);
            end
            if (rgb_out == 6'h0C) n_fg++;
        end
        checks++;
        if (n_fg != 4) begin
            errors++;
            $display("FAIL nowrap_count: got %0d want 4", n_fg);
        end
    endtask

    task automatic test_simultaneous();
        cfg_write(A_POS, pos_word(200, 100));
        vsync_in = 1'b1; irq_clear = 1'b1;
        cfg_addr = A_POS; cfg_wdata = pos_word(300, 200); cfg_we = 1'b1;
        tick();
        checks++;
        if (frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: got %b want 1", frame_irq);
        end
        vsync_in = 1'b0; tick();
        cfg_addr = A_POS; #1;
        checks++;
        if (cfg_rdata !== pos_word(300, 200)) begin
            errors++;
            $display("FAIL pos_pending: got %h want %h", cfg_rdata, pos_word(300, 200));
        end
        hpos = 10'd200; vpos = 10'd100; display_on = 1'b1; tick(); display_on = 1'b0; tick();
        checks++;
        if (rgb_out !== 6'h0C) begin
            errors++;
            $display("FAIL old_pos_active: got %h want 0c", rgb_out);
        end
        hpos = 10'd300; vpos = 10'd200; display_on = 1'b1; tick(); display_on = 1'b0; tick();
        checks++;
        if (rgb_out !== 6'h03) begin
            errors++;
            $display("FAIL new_pos_waits: got %h want 03", rgb_out);
        end
        vsync_pulse();
        hpos = 10'd300; vpos = 10'd200; display_on = 1'b1; tick(); display_on = 1'b0; tick();
        checks++;
        if (rgb_out !== 6'h0C) begin
            errors++;
            $display("FAIL new_pos_next_frame: got %h want 0c", rgb_out);
        end
        hpos = 10'd200; vpos = 10'd100; display_on = 1'b1; tick(); display_on = 1'b0; tick();
        checks++;
        if (rgb_out !== 6'h03) begin
            errors++;
            $display("FAIL old_pos_gone: got %h want 03", rgb_out);
        end
        irq_clear = 1'b1; tick();
        checks++;
        if (frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b want 0", frame_irq);
        end
    endtask

    task automatic test_bitmap();
        cfg_write(A_BMP0, 32'hFFFF_0000);
        cfg_write(A_FRAME, 32'h0000_1234);
        cfg_addr = A_BMP0; #1;
        checks++;
        if (cfg_rdata !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL bmp_readback: got %h want ffff0000", cfg_rdata);
        end
        cfg_addr = 6'h3C; #1;
        checks++;
        if (cfg_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL read_3c: got %h want 0", cfg_rdata);
        end
        cfg_addr = 6'h11; #1;
        checks++;
        if (cfg_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL read_unaligned: got %h want 0", cfg_rdata);
        end
        cfg_addr = A_FRAME; #1;
        checks++;
        if (cfg_rdata !== 32'(m_cnt)) begin
            errors++;
            $display("FAIL frame_ro: got %h want %h", cfg_rdata, 32'(m_cnt));
        end
        cfg_addr = A_CTRL; #1;
        checks++;
        if (cfg_rdata !== 32'h0003_0C01) begin
            errors++;
            $display("FAIL ctrl_read: got %h want 00030c01", cfg_rdata);
        end
        hpos = 10'd300; vpos = 10'd200; display_on = 1'b1; tick(); display_on = 1'b0; tick();
        checks++;
        if (rgb_out !== 6'h03) begin
            errors++;
            $display("FAIL row0_blank: got %h want 03", rgb_out);
        end
        hpos = 10'd305; vpos = 10'd201; display_on = 1'b1; tick(); display_on = 1'b0; tick();
        checks++;
        if (rgb_out !== 6'h0C) begin
            errors++;
            $display("FAIL row1_solid: got %h want 0c", rgb_out);
        end
    endtask

    task automatic test_random();
        logic [5:0] addrs [12] = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18, 6'h1C,
                                   6'h20, 6'h24, 6'h28, 6'h2C, 6'h3C};
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
            hpos = 10'(a_x + int'($urandom_range(0, 19)) - 2);
            vpos = 10'(a_y + int'($urandom_range(0, 19)) - 2);
            display_on = ($urandom_range(0, 7) != 0);
            hsync_in = 1'($urandom);
            vsync_in = ($urandom_range(0, 15) == 0);
            irq_clear = ($urandom_range(0, 7) == 0);
            cfg_addr = addrs[$urandom_range(0, 11)];
            d = $urandom;
            if (cfg_addr == A_POS) d = pos_word(int'($urandom_range(0, 640)), int'($urandom_range(0, 480)));
            cfg_wdata = d;
            #1;
            checks++;
            if (cfg_rdata !== model_read(cfg_addr)) begin
                errors++;
                $display("FAIL rand_read[%0d] @%h: got %h want %h", i, cfg_addr, cfg_rdata, model_read(cfg_addr));
            end
            cfg_we = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (rgb_out !== exp_rgb || hsync_out !== exp_hs || vsync_out !== exp_vs || frame_irq !== m_irq) begin
                errors++;
                $display("FAIL rand_px[%0d]: rgb=%h hs=%b vs=%b irq=%b want rgb=%h hs=%b vs=%b irq=%b",
                         i, rgb_out, hsync_out, vsync_out, frame_irq, exp_rgb, exp_hs, exp_vs, m_irq);
            end
        end
        vsync_in = 1'b0; irq_clear = 1'b0; tick();
    endtask

    task automatic test_frame_wrap();
        int n;
        n = (1 << CNT_W) - m_cnt;
        for (int i = 0; i < n; i++) vsync_pulse();
        cfg_addr = A_FRAME; #1;
        checks++;
        if (cfg_rdata !== 32'h0000_0000 || m_cnt != 0) begin
            errors++;
            $display("FAIL frame_wrap: got %h want 0 (model %0d)", cfg_rdata, m_cnt);
        end
        vsync_pulse();
        cfg_addr = A_FRAME; #1;
        checks++;
        if (cfg_rdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL frame_after_wrap: got %h want 1", cfg_rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0; display_on = 1'b0; hsync_in = 1'b0;
        vsync_in = 1'b0; cfg_addr = 6'h00; cfg_wdata = 32'h0; cfg_we = 1'b0; irq_clear = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_shadow();
        test_sync_latency();
        test_clip();
        test_simultaneous();
        test_bitmap();
        test_random();
        test_frame_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
